fifo_pixel_reader: RTL and testbench
====================================

# fifo_pixel_reader

Drains a first-word-fall-through synchronous FIFO (`sync_fifo_vendor`, FWFT mode) and emits one frame of pixels as a valid/ready stream. Each beat is tagged with start-of-frame, end-of-line and end-of-frame markers. The block sits on the read side of the line/frame FIFOs, between the FIFO and the median-filter window logic. It pops exactly `IMG_W*IMG_H` words per started frame, at up to one word per cycle. A two-entry skid buffer keeps `m_ready` out of the FIFO read-enable path.

## Interface
- `WIDTH`, 8: pixel/FIFO data width.
- `IMG_W`, 640: pixels per line, must be ≥2.
- `IMG_H`, 480: lines per frame, must be ≥1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle frame request; honoured only in IDLE or DONE.
- `busy`  out  1  high while in RUN.
- `frame_done`  out  1  one-cycle pulse after the eof beat has been accepted downstream.
- `fifo_empty`  in  1  FIFO empty flag (FWFT: `fifo_dout` is valid whenever this is low).
- `fifo_dout`  in  WIDTH  FIFO head word.
- `fifo_rd_en`  out  1  pop strobe. Never asserted while `fifo_empty`=1.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data`  out  WIDTH  pixel.
- `m_sof`  out  1  first pixel of the frame (row 0, column 0).
- `m_eol`  out  1  last pixel of each line (column IMG_W-1).
- `m_eof`  out  1  last pixel of the frame; coincides with `m_eol`.

## Operation
- FSM states:
  - IDLE: on `start`, go to RUN and clear `pop_cnt`, `col` and `row`.
  - RUN: when the eof beat is accepted (`m_valid & m_ready & m_eof`), go to DONE.
  - DONE: held for exactly one cycle with `frame_done`=1. On `start`, go to RUN; otherwise go to IDLE.
- `start` in RUN is ignored.
- Pop condition: `fifo_rd_en = (state==RUN) & ~fifo_empty & (pop_cnt < IMG_W*IMG_H) & ~skid_valid`. It depends only on registered state and `fifo_empty`, never on `m_ready`.
- Tagging at pop time:
  - `sof = (pop_cnt==0)`, `eol = (col==IMG_W-1)`, `eof = eol & (row==IMG_H-1)`.
  - The tags travel with the data as a `WIDTH+3`-bit payload.
- Counter update on each pop:
  - `col` wraps from IMG_W-1 to 0 and increments `row` on wrap.
  - `pop_cnt` increments and saturates at `IMG_W*IMG_H`. No pops happen after that point.
- Skid buffer rules:
  - A popped word loads the output register if the output register is empty or is being accepted this cycle. Otherwise it loads the skid register.
  - When the output register is accepted while the skid register is full, the skid contents move into the output register.
- Counter widths:
  - `pop_cnt`: `$clog2(IMG_W*IMG_H+1)`.
  - `col`: `$clog2(IMG_W)`.
  - `row`: `$clog2(IMG_H)`.
- Words in the FIFO beyond one frame are left in place. No implicit drain.

## Timing
- Reset values: state=IDLE; `busy`=0, `frame_done`=0, `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_sof`=`m_eol`=`m_eof`=0; all counters and both buffer valid bits 0.
- Latency:
  - `start` at cycle t puts the FSM in RUN at t+1, so the first pop can occur at t+1.
  - A word popped at cycle p appears on `m_valid`/`m_data` at p+1.
- Throughput is 1 beat/cycle with `m_ready` held high and the FIFO non-empty.
- Backpressure:
  - With `m_ready`=0, at most 2 words are held (output register plus skid). Pops stop once the skid register is full.
  - Pops resume in the cycle after the skid register empties.
- Output stability: while `m_valid`=1 and `m_ready`=0, `m_data` and the tags hold constant.
- FIFO empty mid-frame: pops pause and `m_valid` drops once buffered data is consumed. Counters are preserved and the frame continues when data returns.
- Eof accepted at cycle e: DONE and `frame_done`=1 at e+1. If `start` is also high at e+1, RUN at e+2.
- `rst` mid-frame: all state clears on the next edge. A partial frame is abandoned; FIFO contents are not touched.

## Structure
- The shared package `mf_pkg` holds:
  - the state encoding localparams `ST_IDLE`, `ST_RUN`, `ST_DONE`;
  - the tag bit positions `TAG_SOF`, `TAG_EOL`, `TAG_EOF` within the payload.
- One sub-module, `skid_buffer #(W)`:
  - generic two-entry valid/ready register slice;
  - instantiated with `W=WIDTH+3`;
  - exposes `s_ready = ~skid_valid` to the FSM.
- The FSM and the counters remain in `fifo_pixel_reader`.

## Test plan
- Free-flowing frame. IMG_W=4, IMG_H=2. FIFO preloaded with 0x10..0x17, `m_ready`=1, `start` pulsed.
  - Expect 8 consecutive beats: sof on 0x10, eol on 0x13 and 0x17, eof on 0x17.
  - Expect `frame_done` the cycle after 0x17 is accepted and exactly 8 `fifo_rd_en` pulses.
- Backpressure. Same frame with `m_ready` low for 5 cycles after the 2nd beat.
  - Expect at most 2 words buffered and `fifo_rd_en` low while the skid register is full.
  - Expect `m_data` stable during the stall and no loss or duplication of 0x10..0x17.
- FIFO starvation. `fifo_empty` forced high after 3 pops for 10 cycles, then released.
  - Expect `m_valid`=0 during the gap.
  - Expect the output to resume with 0x13 carrying eol, and tags to stay correct.
- Overfill. FIFO holds 12 words, frame size is 8.
  - Expect exactly 8 pops and 4 words remaining in the FIFO.
  - Expect `start` during RUN to be ignored.
- Back-to-back frames. `start` asserted in the DONE cycle.
  - Expect RUN on the next cycle and sof on the 9th word.
- Reset mid-frame. `rst` pulsed after 5 beats.
  - Expect all outputs at their reset values on the next cycle, state IDLE and `busy`=0.
  - Expect a new `start` to tag the next popped word as sof.

Source files
------------

// File: rtl/mf_pkg.sv
// Shared definitions for the median-filter read path: FSM state encoding
// and the bit positions of the frame tags that ride above the pixel data.
package mf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Tag bits sit directly above the pixel: payload[WIDTH + TAG_x].
    localparam int TAG_SOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 2;
    localparam int TAG_W   = 3;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice. The upstream ready is purely the
// skid-empty flag, so the producer never sees the downstream ready.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    input  logic         m_ready
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         push;
    logic         accept;

    // Next-state for output and skid registers; skid always drains first.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        push         = s_valid & ~skid_valid_q;
        accept       = out_valid_q & m_ready;
        if (accept && skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (push && (!out_valid_q || accept)) begin
            out_valid_d = 1'b1;
            out_data_d  = s_data;
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready = ~skid_valid_q;
    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;

endmodule

// File: rtl/fifo_pixel_reader.sv
// Drains one frame of IMG_W*IMG_H words from an FWFT FIFO and emits them
// as a tagged valid/ready pixel stream (sof / eol / eof).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; no pops
// RUN     | popping and tagging words until the eof beat is accepted
// DONE    | one-cycle frame_done pulse; start here chains the next frame
module fifo_pixel_reader
    import mf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    // A single-line frame would give a zero-width row counter; keep one bit.
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW    = WIDTH + TAG_W;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic             s_ready;
    logic             tag_sof, tag_eol, tag_eof;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;
    logic             out_valid;
    logic             eof_accept;

    // Pop strobe and tags depend only on registered state and fifo_empty.
    always_comb begin
        fifo_rd_en = (state_q == ST_RUN) && !fifo_empty
                     && (pop_cnt_q < CNT_W'(TOTAL)) && s_ready;
        tag_sof    = (pop_cnt_q == '0);
        tag_eol    = (col_q == COL_W'(IMG_W - 1));
        tag_eof    = tag_eol && (row_q == ROW_W'(IMG_H - 1));
        in_payload                   = '0;
        in_payload[WIDTH-1:0]        = fifo_dout;
        in_payload[WIDTH + TAG_SOF]  = tag_sof;
        in_payload[WIDTH + TAG_EOL]  = tag_eol;
        in_payload[WIDTH + TAG_EOF]  = tag_eof;
    end

    assign eof_accept = out_valid & m_ready & out_payload[WIDTH + TAG_EOF];

    // Frame FSM next-state, counter updates and status outputs.
    always_comb begin
        state_d    = state_q;
        pop_cnt_d  = pop_cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pop_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (fifo_rd_en) begin
                    // fifo_rd_en is already gated on pop_cnt < TOTAL,
                    // so this increment saturates at TOTAL.
                    pop_cnt_d = pop_cnt_q + CNT_W'(1);
                    if (tag_eol) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                if (eof_accept) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                if (start) begin
                    state_d   = ST_RUN;
                    pop_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pop_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            pop_cnt_q <= pop_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (fifo_rd_en),
        .s_data  (in_payload),
        .s_ready (s_ready),
        .m_valid (out_valid),
        .m_data  (out_payload),
        .m_ready (m_ready)
    );

    assign m_valid = out_valid;
    assign m_data  = out_payload[WIDTH-1:0];
    assign m_sof   = out_payload[WIDTH + TAG_SOF];
    assign m_eol   = out_payload[WIDTH + TAG_EOL];
    assign m_eof   = out_payload[WIDTH + TAG_EOF];

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Bench for fifo_pixel_reader on a 4x2 frame. The FIFO is a queue; the
// reference treats the reader as a pipeline holding at most two popped
// words, tagged by their index within the frame.
module tb_fifo_pixel_reader;

    localparam int WIDTH = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int TOTAL = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             frame_done;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_sof, m_eol, m_eof;

    always #5 clk = ~clk;

    fifo_pixel_reader #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;

    logic [WIDTH-1:0] fq[$];
    bit               starve;

    beat_t mq[$];
    int    mstate;
    int    mpops;
    bit    after_rst;

    beat_t acc_log[$];
    int    acc_cyc[$];
    int    rd_cnt;
    int    done_cnt;
    int    cyc;
    int    eof_cyc;
    int    done_cyc;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = starve || (fq.size() == 0);
        if (fifo_empty) fifo_dout = '0;
        else            fifo_dout = fq[0];
    endtask

    // One clock: compare outputs with the reference, advance the reference
    // across the coming edge, then let the FIFO queue follow the real pop.
    task automatic tick();
        logic  exp_v, exp_rd, acc, eof_acc, act_rd;
        logic [WIDTH-1:0] head;
        beat_t b, nb;
        drive_fifo();
        #1;
        exp_v  = (mq.size() > 0);
        exp_rd = (mstate == 1) && !fifo_empty && (mpops < TOTAL) && (mq.size() < 2);
        chk("m_valid", 32'(m_valid), 32'(exp_v));
        chk("busy", 32'(busy), 32'(mstate == 1));
        chk("frame_done", 32'(frame_done), 32'(mstate == 2));
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        if (exp_v) begin
            chk("m_data", 32'(m_data), 32'(mq[0].d));
            chk("m_sof", 32'(m_sof), 32'(mq[0].sof));
            chk("m_eol", 32'(m_eol), 32'(mq[0].eol));
            chk("m_eof", 32'(m_eof), 32'(mq[0].eof));
        end else if (after_rst) begin
            chk("m_data_rst", 32'(m_data), 32'h0);
            chk("m_tags_rst", 32'({m_sof, m_eol, m_eof}), 32'h0);
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        act_rd  = fifo_rd_en;
        head    = fifo_dout;
        acc     = exp_v && m_ready;
        eof_acc = 1'b0;
        if (rst) begin
            mstate    = 0;
            mpops     = 0;
            mq.delete();
            after_rst = 1'b1;
        end else begin
            if (acc) begin
                b = mq.pop_front();
                acc_log.push_back(b);
                acc_cyc.push_back(cyc);
                eof_acc = b.eof;
                if (b.eof) eof_cyc = cyc;
            end
            if (exp_rd) begin
                nb.d   = head;
                nb.sof = (mpops == 0);
                nb.eol = ((mpops % IMG_W) == IMG_W - 1);
                nb.eof = (mpops == TOTAL - 1);
                mq.push_back(nb);
                mpops++;
                after_rst = 1'b0;
            end
            case (mstate)
                0: if (start) begin mstate = 1; mpops = 0; end
                1: if (eof_acc) mstate = 2;
                default: begin
                    if (start) begin mstate = 1; mpops = 0; end
                    else mstate = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        if (act_rd === 1'b1) begin
            rd_cnt++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        cyc++;
    endtask

    task automatic load(input int base, input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(WIDTH'(base + i));
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        rd_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int max_cyc);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt != d0), 32'h1);
    endtask

    task automatic check_seq(input string name, input int base, input int first);
        for (int i = 0; i < TOTAL; i++) begin
            if (first + i < acc_log.size()) begin
                chk({name, "_data"}, 32'(acc_log[first + i].d), 32'(base + i));
                chk({name, "_sof"}, 32'(acc_log[first + i].sof), 32'(i == 0));
                chk({name, "_eol"}, 32'(acc_log[first + i].eol), 32'(i == 3 || i == 7));
                chk({name, "_eof"}, 32'(acc_log[first + i].eof), 32'(i == 7));
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] head;
        logic [WIDTH-1:0] words[$];
        int               n;

        rst       = 1'b1;
        start     = 1'b0;
        m_ready   = 1'b1;
        starve    = 1'b0;
        mstate    = 0;
        mpops     = 0;
        after_rst = 1'b1;
        cyc       = 0;
        eof_cyc   = 0;
        done_cyc  = 0;
        clear_logs();
        drive_fifo();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // reset values
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_tags", 32'({m_sof, m_eol, m_eof}), 32'h0);

        // free-flowing frame
        load(8'h10, 8);
        clear_logs();
        start_frame();
        run_until_done("s1", 40);
        tick();
        chk("s1_rd_cnt", 32'(rd_cnt), 32'd8);
        chk("s1_beats", 32'(acc_log.size()), 32'd8);
        check_seq("s1", 8'h10, 0);
        chk("s1_done_latency", 32'(done_cyc - eof_cyc), 32'd1);
        if (acc_cyc.size() == 8) chk("s1_back_to_back", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
        chk("s1_fifo_left", 32'(fq.size()), 32'd0);
        chk("s1_done_pulses", 32'(done_cnt), 32'd1);

        // backpressure
        load(8'h10, 8);
        clear_logs();
        start_frame();
        n = 0;
        while (acc_log.size() < 2 && n < 20) begin tick(); n++; end
        chk("s2_reach_2", 32'(acc_log.size()), 32'd2);
        m_ready = 1'b0;
        tick();
        held = m_data;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s2_stall_data", 32'(m_data), 32'(held));
            chk("s2_occupancy_le2", 32'((rd_cnt - acc_log.size()) <= 2), 32'h1);
            chk("s2_rd_low", 32'(fifo_rd_en), 32'h0);
        end
        m_ready = 1'b1;
        run_until_done("s2", 40);
        chk("s2_rd_cnt", 32'(rd_cnt), 32'd8);
        chk("s2_beats", 32'(acc_log.size()), 32'd8);
        check_seq("s2", 8'h10, 0);

        // FIFO starvation
        load(8'h10, 8);
        clear_logs();
        start_frame();
        n = 0;
        while (rd_cnt < 3 && n < 20) begin tick(); n++; end
        starve = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) chk("s3_gap_valid", 32'(m_valid), 32'h0);
        end
        starve = 1'b0;
        run_until_done("s3", 40);
        chk("s3_beats", 32'(acc_log.size()), 32'd8);
        if (acc_log.size() > 3) begin
            chk("s3_resume_data", 32'(acc_log[3].d), 32'h13);
            chk("s3_resume_eol", 32'(acc_log[3].eol), 32'h1);
        end
        check_seq("s3", 8'h10, 0);

        // overfill, start during RUN ignored
        load(8'h20, 12);
        clear_logs();
        start_frame();
        tick();
        tick();
        start_frame();
        chk("s4_still_busy", 32'(busy), 32'h1);
        run_until_done("s4", 40);
        tick();
        tick();
        chk("s4_rd_cnt", 32'(rd_cnt), 32'd8);
        chk("s4_fifo_left", 32'(fq.size()), 32'd4);
        if (fq.size() > 0) chk("s4_fifo_head", 32'(fq[0]), 32'h28);
        chk("s4_beats", 32'(acc_log.size()), 32'd8);
        check_seq("s4", 8'h20, 0);
        fq.delete();

        // back-to-back frames
        load(8'h30, 16);
        clear_logs();
        start_frame();
        n = 0;
        while (acc_log.size() < 8 && n < 40) begin tick(); n++; end
        chk("s5_in_done", 32'(frame_done), 32'h1);
        start_frame();
        chk("s5_rerun", 32'(busy), 32'h1);
        run_until_done("s5", 40);
        chk("s5_beats", 32'(acc_log.size()), 32'd16);
        check_seq("s5a", 8'h30, 0);
        check_seq("s5b", 8'h38, 8);

        // reset mid-frame
        load(8'h40, 16);
        clear_logs();
        start_frame();
        n = 0;
        while (acc_log.size() < 5 && n < 40) begin tick(); n++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_busy", 32'(busy), 32'h0);
        chk("s6_frame_done", 32'(frame_done), 32'h0);
        chk("s6_rd_en", 32'(fifo_rd_en), 32'h0);
        chk("s6_m_valid", 32'(m_valid), 32'h0);
        chk("s6_m_data", 32'(m_data), 32'h0);
        chk("s6_tags", 32'({m_sof, m_eol, m_eof}), 32'h0);
        tick();
        head = (fq.size() > 0) ? fq[0] : 8'h00;
        clear_logs();
        start_frame();
        run_until_done("s6", 40);
        chk("s6_beats", 32'(acc_log.size()), 32'd8);
        if (acc_log.size() > 0) begin
            chk("s6_first_data", 32'(acc_log[0].d), 32'(head));
            chk("s6_first_sof", 32'(acc_log[0].sof), 32'h1);
        end
        fq.delete();

        // randomized ready and FIFO gaps
        for (int f = 0; f < 4; f++) begin
            fq.delete();
            words.delete();
            for (int i = 0; i < TOTAL + int'($urandom_range(0, 3)); i++) begin
                fq.push_back(WIDTH'($urandom));
                if (i < TOTAL) words.push_back(fq[i]);
            end
            clear_logs();
            start_frame();
            n = 0;
            while (done_cnt == 0 && n < 400) begin
                m_ready = ($urandom_range(0, 3) != 0);
                starve  = ($urandom_range(0, 4) == 0);
                tick();
                n++;
            end
            starve  = 1'b0;
            m_ready = 1'b1;
            chk("rnd_done_seen", 32'(done_cnt), 32'd1);
            chk("rnd_beats", 32'(acc_log.size()), 32'd8);
            for (int i = 0; i < TOTAL && i < acc_log.size(); i++)
                chk("rnd_data", 32'(acc_log[i].d), 32'(words[i]));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
